// File: rtl/jedro_1_mem_arbiter_pkg.sv
// Shared type definitions for the jedro_1 memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY)
//   owner_e     : which requester owns the outstanding transaction (FETCH, DATA)
//   BE_WIDTH    : byte-enable / write-strobe width of the RAM port
//   CNT_WIDTH   : latency counter width (MEM_LATENCY is limited to 1..4)
package jedro_1_defines;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam int unsigned BE_WIDTH  = 4;
  localparam int unsigned CNT_WIDTH = 2;

endpackage

// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle for the jedro_1 memory arbiter.
//   i_* : instruction fetch port (read-only request/grant/response)
//   d_* : load/store port (request/grant/response with write data and byte enables)
//   m_* : single shared synchronous RAM port
// Modports:
//   slave  : seen by the arbiter (takes requests and read data, drives grants and RAM controls)
//   master : seen by the surrounding system (requesters plus RAM)
interface jedro_1_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                                  i_req_i;
  logic [DATA_WIDTH-1:0]                 i_addr_i;
  logic                                  i_gnt_o;
  logic                                  i_rvalid_o;
  logic [DATA_WIDTH-1:0]                 i_rdata_o;

  logic                                  d_req_i;
  logic                                  d_we_i;
  logic [jedro_1_defines::BE_WIDTH-1:0]  d_be_i;
  logic [DATA_WIDTH-1:0]                 d_addr_i;
  logic [DATA_WIDTH-1:0]                 d_wdata_i;
  logic                                  d_gnt_o;
  logic                                  d_rvalid_o;
  logic [DATA_WIDTH-1:0]                 d_rdata_o;

  logic                                  m_en_o;
  logic [jedro_1_defines::BE_WIDTH-1:0]  m_we_o;
  logic [DATA_WIDTH-1:0]                 m_addr_o;
  logic [DATA_WIDTH-1:0]                 m_wdata_o;
  logic [DATA_WIDTH-1:0]                 m_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output m_en_o, m_we_o, m_addr_o, m_wdata_o,
    input  m_rdata_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  m_en_o, m_we_o, m_addr_o, m_wdata_o,
    output m_rdata_i
  );

endinterface

// File: rtl/jedro_1_mem_arbiter_rr_arb.sv
// Two-way round-robin grant logic.
//   req_i  : request vector, bit 0 = fetch, bit 1 = data
//   last_i : port granted most recently
//   en_i   : grant slot open; no grant is issued when low
//   gnt_o  : one-hot grant (bit 0 = fetch, bit 1 = data), all-zero when idle
module jedro_1_rr_arb
  import jedro_1_defines::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // On conflict the port that did not win last time goes next.
        2'b11:   gnt_o = (last_i == DATA) ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Arbitrates the instruction fetch port and the load/store port onto one
// shared synchronous RAM port with a fixed read latency. One transaction
// is outstanding at a time; a new one may be granted in the cycle the
// current one completes, giving one transaction per MEM_LATENCY cycles.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset; all outputs forced low while high
//   bus   : fetch, load/store and RAM signals (slave modport)
// Parameters:
//   DATA_WIDTH  : data and address width
//   MEM_LATENCY : cycles from m_en_o to valid m_rdata_i (1..4)
module jedro_1_mem_arbiter
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  jedro_1_mem_arbiter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_LATENCY - 1);

  arb_state_e           state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  owner_e               owner_q;
  owner_e               last_q;
  logic                 wr_q;

  logic                 done;
  logic                 slot;
  logic [1:0]           gnt;
  logic [DATA_WIDTH-1:0] rdata_rd;

  // Completion cycle of the outstanding transaction; doubles as a grant slot.
  assign done = (state_q == BUSY) && (cnt_q == CNT_LAST) && !rst_i;
  assign slot = !rst_i && ((state_q == IDLE) || done);

  jedro_1_rr_arb u_rr_arb (
    .req_i  ({bus.d_req_i, bus.i_req_i}),
    .last_i (last_q),
    .en_i   (slot),
    .gnt_o  (gnt)
  );

  assign rdata_rd = bus.m_rdata_i;

  always_comb begin
    bus.i_gnt_o    = gnt[0];
    bus.d_gnt_o    = gnt[1];
    bus.m_en_o     = 1'b0;
    bus.m_we_o     = '0;
    bus.m_addr_o   = '0;
    bus.m_wdata_o  = '0;
    bus.i_rvalid_o = 1'b0;
    bus.i_rdata_o  = '0;
    bus.d_rvalid_o = 1'b0;
    bus.d_rdata_o  = '0;

    if (gnt[0]) begin
      bus.m_en_o   = 1'b1;
      bus.m_addr_o = bus.i_addr_i;
    end else if (gnt[1]) begin
      bus.m_en_o   = 1'b1;
      bus.m_addr_o = bus.d_addr_i;
      if (bus.d_we_i) begin
        bus.m_we_o    = bus.d_be_i;
        bus.m_wdata_o = bus.d_wdata_i;
      end
    end

    if (done) begin
      if (owner_q == FETCH) begin
        bus.i_rvalid_o = 1'b1;
        bus.i_rdata_o  = rdata_rd;
      end else begin
        bus.d_rvalid_o = 1'b1;
        bus.d_rdata_o  = wr_q ? '0 : rdata_rd;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= FETCH;
      wr_q    <= 1'b0;
      last_q  <= DATA;
    end else if (gnt != 2'b00) begin
      state_q <= BUSY;
      cnt_q   <= '0;
      owner_q <= gnt[1] ? DATA : FETCH;
      wr_q    <= gnt[1] & bus.d_we_i;
      last_q  <= gnt[1] ? DATA : FETCH;
    end else if (state_q == BUSY) begin
      if (cnt_q == CNT_LAST) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule
